tick_gen: RTL and testbench
===========================

Name: tick_gen

Overview:
- Parametrised, multi-channel timebase for the stopwatch datapath; the successor to the fixed clk_1hz/clk_2hz/clk_4hz/clk_fst divider.
- Each of NUM_CH channels has its own period in clk cycles and produces two outputs:
  - a one-cycle enable pulse (tick);
  - a registered 50% square wave (sq), used for digit blink.
- Adds three things the old divider lacks: synchronous reset, global run/hold, and a phase-aligned restart of all channels.
- Consumers use tick as a clock enable; none of the outputs are routed as clocks.

Parameters:
- NUM_CH, 4, number of channels.
- CNT_W, 27, counter width per channel.
- PERIODS, {27'd200_000, 27'd25_000_000, 27'd50_000_000, 27'd100_000_000}, packed NUM_CH*CNT_W vector. Channel i is in bits [i*CNT_W +: CNT_W], so ch0 = 1 Hz, ch1 = 2 Hz, ch2 = 4 Hz, ch3 = 500 Hz at 100 MHz.
- SIM_SCALE, 1000, period divisor. Used only when TICK_GEN_SIM_SCALE_EN is defined.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  synchronous active-low reset
- en  in  1  global run; 0 = hold all channels
- sync_clr  in  1  synchronous restart of all channels to phase 0
- tick  out  NUM_CH  per-channel one-cycle pulse at end of period
- sq  out  NUM_CH  per-channel 50% square wave

Behaviour:
- Single clock domain. Reset is synchronous, active-low, sampled on posedge clk. Priority: rst_n=0 > sync_clr=1 > en.
- Elaboration check, per channel P_i:
  - P_i must be even, >= 2 and <= 2^CNT_W - 1.
  - A violation stops elaboration with an error message naming the channel.
- Reset (rst_n=0 at an edge): every cnt_i = 0, tick = 0, sq = 0.
- sync_clr=1 with rst_n=1: same effect as reset on all channels, regardless of en.
- en=0 (no reset, no clear):
  - cnt_i and sq_i hold;
  - tick = 0 on the next edge, so a held timebase never emits ticks.
- en=1: cnt_i advances 0 .. P_i-1, then wraps to 0. Counting enabled edges k = 1, 2, ... from the last reset/clear:
  - cnt_i after edge k = k mod P_i.
  - tick_i is high for exactly the one cycle following each edge where k mod P_i == 0 (k > 0).
  - sq_i is high after any edge where (k mod P_i) >= P_i/2, otherwise low. It rises after edge P_i/2 and falls after edge P_i, on the same edge tick_i asserts.
- Latency: all outputs are registered, with no combinational path from inputs to outputs.
- Hold mid-period: en dropped for N cycles stretches the current period by exactly N cycles. Phase is preserved; no tick is lost or duplicated.
- Phase alignment: after reset or sync_clr, channels with periods P_a | P_b tick together every P_b cycles.
- P_i = 2: tick_i high every other cycle; sq_i toggles every cycle.
- Reset or sync_clr asserted in the same cycle as a wrap: the wrap is discarded and tick is 0 on the next cycle.
- Channels are fully independent: no shared counter, and no cross-channel carry.

Optional Feature:
- Macro: TICK_GEN_SIM_SCALE_EN.
- Defined: effective period Pe_i = P_i / SIM_SCALE, rounded down to even, minimum 2. Used for fast simulation of the stopwatch top level. All other behaviour is identical using Pe_i.
- Not defined: Pe_i = P_i; SIM_SCALE is ignored; no extra logic.

Test Plan:
- Setup for all scenarios: PERIODS ch0=2, ch1=4, ch2=8, ch3=6; NUM_CH=4; CNT_W=4.
- Basic timing: rst_n=0 for 3 cycles, then rst_n=1, en=1. Expect:
  - tick = 0 and sq = 0 during reset;
  - tick0 after edges 2, 4, 6...;
  - tick1 after edges 4, 8;
  - tick3 after edges 6, 12;
  - sq2 high after edges 4–7, low after edge 8;
  - all ticks high together after edge 24.
- Hold: en=1 for 5 edges, en=0 for 3 edges, en=1. Expect:
  - no tick during the hold;
  - sq values frozen during the hold;
  - tick2 after enabled edge 8 (absolute edge 11).
- sync_clr: pulse for 1 cycle at cnt2=5 with en=1. Expect:
  - all tick = 0 and all sq = 0 next cycle;
  - tick2 next asserts exactly 8 enabled edges after the clear.
- Reset mid-operation: rst_n=0 for 1 cycle on the same edge where cnt1 wraps. Expect:
  - tick1 stays 0;
  - all counters restart from 0;
  - first tick1 4 edges after release.
- Macro: define TICK_GEN_SIM_SCALE_EN with SIM_SCALE=1000 and P=100_000_000. Expect tick period 100_000 cycles. With P=3000, Pe rounds down to 2.
- Elaboration: PERIODS ch1=5 (odd). Expect elaboration error naming channel 1.

Source files
------------

// File: rtl/tick_gen.sv
// Purpose : multi-channel timebase; per-channel one-cycle tick enable and 50% square wave.
// Latency : all outputs are registered; tick/sq change on the edge after the counting edge.
// Backpressure: none; en=0 holds every channel (counters and sq frozen, tick forced low).
//
// Ports:
//   clk      in            system clock
//   rst_n    in            synchronous active-low reset (highest priority)
//   en       in            global run; 0 = hold all channels
//   sync_clr in            synchronous restart of all channels to phase 0 (beats en)
//   tick     out [NUM_CH]  one-cycle pulse at the end of each channel's period
//   sq       out [NUM_CH]  square wave, high for the second half of each period
//
// Optional macro TICK_GEN_SIM_SCALE_EN: divides every period by SIM_SCALE
// (rounded down to even, minimum 2) for fast top-level simulation.
module tick_gen #(
    parameter int                        NUM_CH    = 4,
    parameter int                        CNT_W     = 27,
    parameter logic [NUM_CH*CNT_W-1:0]   PERIODS   = {27'd200_000, 27'd25_000_000,
                                                      27'd50_000_000, 27'd100_000_000},
    parameter int                        SIM_SCALE = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync_clr,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq
);

    localparam longint MAX_P = (longint'(1) << CNT_W) - 1;

`ifdef TICK_GEN_SIM_SCALE_EN
    // Scaled period: divide, force even so sq stays 50%, never below 2.
    function automatic longint eff_period(input longint p);
        longint e;
        e = p / longint'(SIM_SCALE);
        e = e - (e % 2);
        if (e < 2) e = 2;
        return e;
    endfunction
`endif

    if (SIM_SCALE < 1) begin : g_bad_scale
        $error("tick_gen: SIM_SCALE must be >= 1 (got %0d)", SIM_SCALE);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam longint P_RAW = longint'(PERIODS[i*CNT_W +: CNT_W]);
`ifdef TICK_GEN_SIM_SCALE_EN
        localparam longint PE = eff_period(P_RAW);
`else
        localparam longint PE = P_RAW;
`endif
        localparam logic [CNT_W-1:0] LAST = CNT_W'(PE - 1);
        localparam logic [CNT_W-1:0] HALF = CNT_W'(PE / 2);

        if ((P_RAW % 2) != 0 || P_RAW < 2 || P_RAW > MAX_P) begin : g_bad_period
            $error("tick_gen: channel %0d period %0d must be even, >= 2 and fit CNT_W",
                   i, P_RAW);
        end

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             tick_q, tick_d;
        logic             sq_q, sq_d;
        logic             wrap;

        assign wrap = (cnt_q == LAST);

        always_comb begin
            cnt_d  = cnt_q;
            tick_d = 1'b0;
            sq_d   = sq_q;
            if (sync_clr) begin
                // Clear wins over en; a wrap on this edge is discarded.
                cnt_d = '0;
                sq_d  = 1'b0;
            end else if (en) begin
                cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
                tick_d = wrap;
                // sq is high while the post-edge count sits in the upper half.
                sq_d   = (cnt_d >= HALF);
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                tick_q <= tick_d;
                sq_q   <= sq_d;
            end
        end

        assign tick[i] = tick_q;
        assign sq[i]   = sq_q;
    end

endmodule

// File: tb/tb_tick_gen.sv
// Purpose : self-checking bench for tick_gen with periods ch0=2, ch1=4, ch2=8, ch3=6.
// Latency : samples outputs 1 time unit after each rising edge.
// Backpressure: n/a; inputs driven directly from the stimulus process.
module tb_tick_gen;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 4;
    localparam logic [NUM_CH*CNT_W-1:0] PER = {4'd6, 4'd8, 4'd4, 4'd2};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              sync_clr;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;

    int n_checks = 0;
    int n_pass   = 0;

    tick_gen #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .PERIODS  (PER),
        .SIM_SCALE(1000)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sync_clr(sync_clr),
        .tick    (tick),
        .sq      (sq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       clr;
        logic [3:0] tick;
        logic [3:0] sq;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic e, input logic c,
                       input logic [3:0] t, input logic [3:0] s);
        vec_t v;
        v.rst_n = r; v.en = e; v.clr = c; v.tick = t; v.sq = s;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic step(input logic r, input logic e, input logic c);
        rst_n = r; en = e; sync_clr = c;
        @(posedge clk);
        #1;
    endtask

    // Run enabled edges until tick[ch] is seen; returns edge count or -1 on timeout.
    task automatic wait_tick(input int ch, input int budget, output int edges);
        edges = -1;
        for (int n = 1; n <= budget; n++) begin
            step(1'b1, 1'b1, 1'b0);
            if (tick[ch]) begin
                edges = n;
                break;
            end
        end
    endtask

    initial begin
        int       got;
        int       early_all;
        logic [3:0] sq_frz;

        rst_n = 1'b0; en = 1'b1; sync_clr = 1'b0;

        // rst en clr   tick     sq
        add(0, 1, 0, 4'b0000, 4'b0000);
        add(0, 1, 0, 4'b0000, 4'b0000);
        add(0, 1, 0, 4'b0000, 4'b0000);
        add(1, 1, 0, 4'b0000, 4'b0001); // k1
        add(1, 1, 0, 4'b0001, 4'b0010); // k2
        add(1, 1, 0, 4'b0000, 4'b1011); // k3
        add(1, 1, 0, 4'b0011, 4'b1100); // k4
        add(1, 1, 0, 4'b0000, 4'b1101); // k5
        add(1, 1, 0, 4'b1001, 4'b0110); // k6
        add(1, 1, 0, 4'b0000, 4'b0111); // k7
        add(1, 1, 0, 4'b0111, 4'b0000); // k8
        add(1, 1, 0, 4'b0000, 4'b1001); // k9
        add(1, 1, 0, 4'b0001, 4'b1010); // k10
        add(1, 1, 0, 4'b0000, 4'b1011); // k11
        add(1, 1, 0, 4'b1011, 4'b0100); // k12
        add(1, 0, 0, 4'b0000, 4'b0100); // hold
        add(1, 0, 0, 4'b0000, 4'b0100);
        add(1, 0, 0, 4'b0000, 4'b0100);
        add(1, 1, 0, 4'b0000, 4'b0101); // k13
        add(1, 1, 0, 4'b0001, 4'b0110); // k14
        add(1, 1, 0, 4'b0000, 4'b1111); // k15
        add(1, 1, 0, 4'b0111, 4'b1000); // k16
        add(1, 1, 0, 4'b0000, 4'b1001); // k17
        add(1, 1, 0, 4'b1001, 4'b0010); // k18
        add(1, 1, 0, 4'b0000, 4'b0011); // k19
        add(1, 1, 0, 4'b0011, 4'b0100); // k20
        add(1, 1, 0, 4'b0000, 4'b1101); // k21, cnt2=5
        add(1, 1, 1, 4'b0000, 4'b0000); // clear
        add(1, 1, 0, 4'b0000, 4'b0001); // k1
        add(1, 1, 0, 4'b0001, 4'b0010); // k2
        add(1, 0, 1, 4'b0000, 4'b0000); // clear with en=0
        add(1, 0, 0, 4'b0000, 4'b0000); // held at phase 0
        add(1, 1, 0, 4'b0000, 4'b0001); // k1

        for (int r = 0; r < tbl.size(); r++) begin
            step(tbl[r].rst_n, tbl[r].en, tbl[r].clr);
            check($sformatf("row%0d_tick", r), int'(tick), int'(tbl[r].tick));
            check($sformatf("row%0d_sq", r),   int'(sq),   int'(tbl[r].sq));
        end

        // Hold: 5 enabled, 3 held, then tick2 at absolute edge 11.
        step(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) step(1'b1, 1'b1, 1'b0);
        sq_frz = sq;
        for (int n = 0; n < 3; n++) begin
            step(1'b1, 1'b0, 1'b0);
            check($sformatf("hold%0d_tick", n), int'(tick), 0);
            check($sformatf("hold%0d_sq", n),   int'(sq),   int'(sq_frz));
        end
        wait_tick(2, 20, got);
        check("hold_tick2_abs_edge", (got < 0) ? -1 : got + 8, 11);

        // All channels tick together first at edge 24 (lcm of 2,4,8,6).
        step(1'b0, 1'b0, 1'b0);
        early_all = 0;
        for (int n = 1; n < 24; n++) begin
            step(1'b1, 1'b1, 1'b0);
            if (tick == 4'b1111) early_all++;
        end
        check("all_tick_before_24", early_all, 0);
        step(1'b1, 1'b1, 1'b0);
        check("all_tick_edge24", int'(tick), 4'b1111);

        // sync_clr at cnt2=5: tick2 exactly 8 enabled edges later.
        step(1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("clr_tick", int'(tick), 0);
        check("clr_sq", int'(sq), 0);
        wait_tick(2, 20, got);
        check("clr_tick2_edges", got, 8);

        // Reset on the edge where cnt1 wraps: wrap discarded, restart from 0.
        step(1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("rst_wrap_tick", int'(tick), 0);
        check("rst_wrap_sq", int'(sq), 0);
        wait_tick(1, 20, got);
        check("rst_tick1_edges", got, 4);

        // ch0 (P=2): tick every other edge, sq toggles every edge.
        step(1'b0, 1'b1, 1'b0);
        for (int n = 1; n <= 6; n++) begin
            step(1'b1, 1'b1, 1'b0);
            check($sformatf("p2_tick_k%0d", n), int'(tick[0]), (n % 2 == 0) ? 1 : 0);
            check($sformatf("p2_sq_k%0d", n),   int'(sq[0]),   (n % 2 == 1) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past 200000 time units, expected finish");
        $fatal(1);
    end

endmodule
